// File: rtl/instr_encoder.sv
// instr_encoder: packs {kind, rd, rs1, rs2, imm} requests into RV32I instruction words for the
// R / ADDI / LW / SW / BEQ / LUI classes and streams {address, word} pairs through a small FIFO
// towards the instruction-memory loader. Illegal requests are consumed and flagged on err.
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_word,
  output logic              err
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = ADDR_W + 32;
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

  localparam logic [3:0] KindAdd  = 4'd0;
  localparam logic [3:0] KindSub  = 4'd1;
  localparam logic [3:0] KindAnd  = 4'd2;
  localparam logic [3:0] KindOr   = 4'd3;
  localparam logic [3:0] KindAddi = 4'd4;
  localparam logic [3:0] KindLw   = 4'd5;
  localparam logic [3:0] KindSw   = 4'd6;
  localparam logic [3:0] KindBeq  = 4'd7;
  localparam logic [3:0] KindLui  = 4'd8;

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpImm  = 7'b0010011;
  localparam logic [6:0] OpLoad = 7'b0000011;
  localparam logic [6:0] OpStor = 7'b0100011;
  localparam logic [6:0] OpBr   = 7'b1100011;
  localparam logic [6:0] OpLui  = 7'b0110111;

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              imm12_ok;
  logic              br_ok;
  logic              accept;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] wr_addr;
  logic [EntW-1:0]   head;

  logic [EntW-1:0]   mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;

  // A 12-bit signed immediate fits when bits 31..11 are a pure sign extension.
  assign imm12_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  // Branch offsets are 13-bit signed and must be even.
  assign br_ok    = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];

  // Combinational encode and legality check of the presented request.
  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (in_kind)
      KindAdd:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, OpR};
      KindSub:  enc_word = {7'b0100000, in_rs2, in_rs1, 3'b000, in_rd, OpR};
      KindAnd:  enc_word = {7'b0000000, in_rs2, in_rs1, 3'b111, in_rd, OpR};
      KindOr:   enc_word = {7'b0000000, in_rs2, in_rs1, 3'b110, in_rd, OpR};
      KindAddi: begin
        enc_word  = {in_imm[11:0], in_rs1, 3'b000, in_rd, OpImm};
        enc_legal = imm12_ok;
      end
      KindLw: begin
        enc_word  = {in_imm[11:0], in_rs1, 3'b010, in_rd, OpLoad};
        enc_legal = imm12_ok;
      end
      KindSw: begin
        enc_word  = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OpStor};
        enc_legal = imm12_ok;
      end
      KindBeq: begin
        enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000, in_imm[4:1], in_imm[11],
                     OpBr};
        enc_legal = br_ok;
      end
      KindLui:  enc_word = {in_imm[31:12], in_rd, OpLui};
      default:  enc_legal = 1'b0;
    endcase
  end

  // Full FIFO never pushes, even when the head is leaving the same cycle.
  assign in_ready  = (count_q < CntW'(DEPTH));
  assign accept    = in_valid & in_ready;
  assign push      = accept & enc_legal;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // restart takes effect for a request accepted in the same cycle.
  assign wr_addr   = restart ? BaseAddr : addr_q;

  assign head     = mem_q[rd_ptr_q];
  assign out_addr = out_valid ? head[EntW-1:32] : '0;
  assign out_word = out_valid ? head[31:0] : '0;
  assign err      = err_q;

  // FIFO storage; contents are meaningless while count is zero, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {wr_addr, enc_word};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Word-address counter; illegal requests leave it untouched unless restart is pulsed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= BaseAddr;
    end else if (push) begin
      addr_q <= wr_addr + ADDR_W'(1);
    end else if (restart) begin
      addr_q <= BaseAddr;
    end
  end

  // One-cycle error pulse after an illegal request is consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept & ~enc_legal;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a default instance and a 2-bit-address instance share one request
// stream; each has its own scoreboard of expected {addr, word} entries.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        restart;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_addr;
  logic [31:0] out_word;
  logic        err;

  logic        w_in_ready;
  logic        w_out_valid;
  logic [1:0]  w_out_addr;
  logic [31:0] w_out_word;
  logic        w_err;

  logic [40:0] sb_q [$];
  logic [33:0] sbw_q [$];
  logic [8:0]  exp_addr;
  logic [1:0]  exp_addr_w;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_word  (out_word),
    .err       (err)
  );

  instr_encoder #(.ADDR_W(2)) dut_w (
    .clk       (clk),
    .reset     (reset),
    .restart   (restart),
    .in_valid  (in_valid),
    .in_ready  (w_in_ready),
    .in_kind   (in_kind),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (w_out_valid),
    .out_ready (out_ready),
    .out_addr  (w_out_addr),
    .out_word  (w_out_word),
    .err       (w_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one request (at posedge+1), wait for in_ready, record expectations, let it be accepted.
  task automatic send(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input bit legal,
                      input logic [31:0] w, input bit rs);
    logic [8:0] a;
    logic [1:0] aw;
    int t;
    in_kind  = k;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    in_valid = 1'b1;
    restart  = rs;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t == 50) check("ready_timeout", 64'd0, 64'd1);
    if (legal) begin
      a  = rs ? 9'd0 : exp_addr;
      aw = rs ? 2'd0 : exp_addr_w;
      sb_q.push_back({a, w});
      sbw_q.push_back({aw, w});
      exp_addr   = a + 9'd1;
      exp_addr_w = aw + 2'd1;
    end else if (rs) begin
      exp_addr   = 9'd0;
      exp_addr_w = 2'd0;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    restart  = 1'b0;
    check("err", {63'd0, err}, {63'd0, !legal});
    if (!legal) begin
      @(posedge clk);
      #1;
      check("err_clr", {63'd0, err}, 64'd0);
    end
  endtask

  // Scoreboard for the default instance.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_empty", 64'd0, 64'd1);
      end else begin
        logic [40:0] e;
        e = sb_q.pop_front();
        check("addr", {55'd0, out_addr}, {55'd0, e[40:32]});
        check("word", {32'd0, out_word}, {32'd0, e[31:0]});
      end
    end
  end

  // Scoreboard for the 2-bit-address instance.
  always @(negedge clk) begin
    if (reset === 1'b1 && w_out_valid && out_ready) begin
      if (sbw_q.size() == 0) begin
        check("sbw_empty", 64'd0, 64'd1);
      end else begin
        logic [33:0] e;
        e = sbw_q.pop_front();
        check("w_addr", {62'd0, w_out_addr}, {62'd0, e[33:32]});
        check("w_word", {32'd0, w_out_word}, {32'd0, e[31:0]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; restart = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_kind = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    exp_addr = '0; exp_addr_w = '0;
    #12;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_addr", {55'd0, out_addr}, 64'd0);
    check("rst_out_word", {32'd0, out_word}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Basic encodes; first also checks one-cycle latency into an empty FIFO.
    send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3, 1'b0);
    check("latency", {63'd0, out_valid}, 64'd1);
    send(4'd4, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF00293, 1'b0);
    send(4'd6, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0020A423, 1'b0);
    send(4'd7, 5'd0, 5'd1, 5'd2, -32'sd4, 1'b1, 32'hFE208EE3, 1'b0);
    send(4'd8, 5'd7, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h123453B7, 1'b0);
    send(4'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h402081B3, 1'b0);
    send(4'd2, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h0020F1B3, 1'b0);
    send(4'd3, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h0020E1B3, 1'b0);
    send(4'd5, 5'd5, 5'd1, 5'd0, 32'd4, 1'b1, 32'h0040A283, 1'b0);
    // Immediate range boundaries (legal).
    send(4'd4, 5'd1, 5'd0, 5'd0, 32'd2047, 1'b1, 32'h7FF00093, 1'b0);
    send(4'd4, 5'd1, 5'd0, 5'd0, -32'sd2048, 1'b1, 32'h80000093, 1'b0);
    send(4'd7, 5'd0, 5'd0, 5'd0, 32'd4094, 1'b1, 32'h7E000FE3, 1'b0);
    send(4'd7, 5'd0, 5'd0, 5'd0, -32'sd4096, 1'b1, 32'h80000063, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Illegal requests: consumed, err pulse, nothing queued, address unchanged.
    send(4'd4, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'd0, 1'b0);
    check("ill_no_push", {63'd0, out_valid}, 64'd0);
    send(4'd12, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 32'd0, 1'b0);
    send(4'd7, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 32'd0, 1'b0);
    send(4'd6, 5'd0, 5'd1, 5'd2, -32'sd2049, 1'b0, 32'd0, 1'b0);
    send(4'd7, 5'd0, 5'd1, 5'd2, 32'd4096, 1'b0, 32'd0, 1'b0);
    check("ill_no_push2", {63'd0, out_valid}, 64'd0);
    send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3, 1'b0);

    // Backpressure: fill, then one pop frees a slot.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(4'd0, 5'd4, 5'd1, 5'd2, 32'd0, 1'b1, 32'h00208233, 1'b0);
    send(4'd0, 5'd5, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002082B3, 1'b0);
    send(4'd0, 5'd6, 5'd1, 5'd2, 32'd0, 1'b1, 32'h00208333, 1'b0);
    send(4'd0, 5'd7, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002083B3, 1'b0);
    check("full_ready", {63'd0, in_ready}, 64'd0);
    check("full_ready_w", {63'd0, w_in_ready}, 64'd0);
    check("full_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("pop_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("drained", {63'd0, out_valid}, 64'd0);

    // restart does not flush; restart with accept lands at BASE_ADDR, next at BASE_ADDR+1.
    out_ready = 1'b0;
    send(4'd4, 5'd1, 5'd0, 5'd0, 32'd1, 1'b1, 32'h00100093, 1'b0);
    send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3, 1'b1);
    send(4'd4, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF00293, 1'b0);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    // Standalone restart pulse, then a legal request.
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    exp_addr = 9'd0;
    exp_addr_w = 2'd0;
    send(4'd8, 5'd7, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h123453B7, 1'b0);
    send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset with entries queued.
    out_ready = 1'b0;
    send(4'd0, 5'd4, 5'd1, 5'd2, 32'd0, 1'b1, 32'h00208233, 1'b0);
    send(4'd0, 5'd5, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002082B3, 1'b0);
    send(4'd0, 5'd6, 5'd1, 5'd2, 32'd0, 1'b1, 32'h00208333, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("async_valid", {63'd0, out_valid}, 64'd0);
    check("async_ready", {63'd0, in_ready}, 64'd1);
    check("async_addr", {55'd0, out_addr}, 64'd0);
    sb_q.delete();
    sbw_q.delete();
    exp_addr = 9'd0;
    exp_addr_w = 2'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h002081B3, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("sb_left", 64'(sb_q.size()), 64'd0);
    check("sbw_left", 64'(sbw_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
